// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   - FSM state encoding (raw localparams plus the enum built on them)
//   - requester port indices
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic PORT_IF = 1'b0;  // instruction fetch
  localparam logic PORT_LS = 1'b1;  // load/store

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_ACCESS = ST_ACCESS,
    S_DONE   = ST_DONE
  } state_t;

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way grant selection.
// Ports:
//   req0, req1  - pending requests from port 0 / port 1
//   last_grant  - port that completed the previous access
//   any_req     - at least one request pending
//   grant       - index of the winning port (valid when any_req)
// Configuration macro ARB_FIXED_PRIORITY_EN: when defined, port 1 wins
// every tie and last_grant is ignored; otherwise ties alternate.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic any_req,
  output logic grant
);

  assign any_req = req0 | req1;

`ifdef ARB_FIXED_PRIORITY_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // Load/store takes the memory whenever it asks.
  assign grant = req1 ? PORT_LS : PORT_IF;
`else
  always_comb begin
    grant = PORT_IF;
    if (req0 && req1) begin
      // Tie goes to whichever port did not win last time.
      grant = ~last_grant;
    end else if (req1) begin
      grant = PORT_LS;
    end
  end
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Shares a single-port word memory between port 0 (instruction fetch) and
// port 1 (load/store). Each access takes IDLE -> ACCESS -> DONE; the ack
// pulse for the served port is high during DONE.
// Ports:
//   clock, reset                 - clock, synchronous active-high reset
//   reqN/weN/addrN/wdataN        - request, write enable, address, write data
//   ackN                         - one-cycle completion pulse
//   rdataN                       - last read data for port N
//   mem_address, mem_wr          - memory address and write strobe
//   mem_data                     - bidirectional memory data bus
// Configuration macro ARB_FIXED_PRIORITY_EN selects fixed priority to
// port 1 instead of round-robin (handled in arb_rr2).
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 27
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_wr,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

  state_t                state;
  logic                  grant;
  logic                  last_grant;
  logic                  gnt_next;
  logic                  any_req;
  logic [DATA_WIDTH-1:0] wdata_lat;

  arb_rr2 u_arb (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .any_req    (any_req),
    .grant      (gnt_next)
  );

  // Write data is held locally so the requester may drop its inputs
  // once the access has started.
  always_ff @(posedge clock) begin
    if (state == S_IDLE && any_req) begin
      wdata_lat <= (gnt_next == PORT_LS) ? wdata1 : wdata0;
    end
  end

  // Only drive the bus during a write; the memory owns it otherwise.
  assign mem_data = mem_wr ? wdata_lat : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      grant       <= PORT_IF;
      last_grant  <= PORT_LS;  // makes port 0 win the first tie
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      mem_wr      <= 1'b0;
      mem_address <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant       <= gnt_next;
            mem_address <= (gnt_next == PORT_LS) ? addr1 : addr0;
            mem_wr      <= (gnt_next == PORT_LS) ? we1 : we0;
            state       <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // Address and wr have been stable for a full cycle; a read
          // result is on the bus now, a write is committed on this edge.
          if (!mem_wr) begin
            if (grant == PORT_LS) rdata1 <= mem_data;
            else                  rdata0 <= mem_data;
          end
          mem_wr     <= 1'b0;
          ack0       <= (grant == PORT_IF);
          ack1       <= (grant == PORT_LS);
          last_grant <= grant;
          state      <= S_DONE;
        end
        S_DONE: begin
          // Requests are deliberately ignored here; a held req is seen
          // again as a fresh request once back in IDLE.
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          ack0   <= 1'b0;
          ack1   <= 1'b0;
          mem_wr <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
